cam_capture_param: RTL and testbench

Parametrised successor to the fixed 160x120 capture path. Runs in the camera pixel-clock domain and takes 8-bit camera bytes framed by href/vsync. It assembles two bytes into one pixel, converts the pixel to the selected storage format and optionally decimates in X and Y. The result is written row-major into the dual-port frame buffer through a regW/addr/data write port. Adds arm/single-shot/continuous capture control, frame-done pulse, frame counter and a sticky overflow flag.

---
 rtl/cam_capture_param.sv | 210 +++++++++++++++++++++
 tb/tb_cam_capture_param.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_param.sv
// cam_capture_param: camera byte-stream capture into a dual-port frame buffer.
// Assembles two camera bytes into one pixel, converts the pixel to the storage
// format, optionally decimates by DECIM in X and Y, and writes the result
// row-major through a single-cycle write port. Capture is either single-shot
// or continuous, under arm/continuous control.
//
// Ports:
//   clk            camera pixel clock, rising edge
//   rst            asynchronous active-low reset
//   CAM_px_data    camera data byte
//   CAM_href       line valid
//   CAM_vsync      frame blanking (high = blanking)
//   arm            level, starts a capture from IDLE
//   continuous     re-arm automatically after each frame
//   DP_RAM_regW    write strobe, one cycle per stored pixel
//   DP_RAM_addr_in write address (held between writes)
//   DP_RAM_data_in write data (held between writes)
//   frame_done     one-cycle pulse at the end of a captured frame
//   busy           high while a capture is armed or running
//   overflow       sticky: a kept pixel fell outside IMG_W x IMG_H
//   frame_cnt      completed frame count, wraps
module cam_capture_param #(
    parameter int unsigned AW    = 15,
    parameter int unsigned DW    = 12,
    parameter int unsigned IMG_W = 160,
    parameter int unsigned IMG_H = 120,
    parameter int unsigned DECIM = 1,
    parameter int unsigned FMT   = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    CAM_px_data,
    input  logic          CAM_href,
    input  logic          CAM_vsync,
    input  logic          arm,
    input  logic          continuous,
    output logic          DP_RAM_regW,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          frame_done,
    output logic          busy,
    output logic          overflow,
    output logic [7:0]    frame_cnt
);

    localparam int unsigned XW = $clog2(IMG_W + 1);
    localparam int unsigned YW = $clog2(IMG_H + 1);
    localparam int unsigned SW = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t         state;
    logic           vs_q;
    logic           href_q;
    logic           phase;
    logic [7:0]     hi_q;
    logic [SW-1:0]  x_sub;
    logic [SW-1:0]  y_sub;
    logic [XW-1:0]  out_x;
    logic [YW-1:0]  out_y;
    logic [AW-1:0]  line_base;
    logic           line_kept;

    logic           frame_start;
    logic           frame_end;
    logic           line_end;
    logic           keep;
    logic           in_bounds;
    logic [SW-1:0]  x_sub_nxt;
    logic [SW-1:0]  y_sub_nxt;
    logic [DW-1:0]  pix;

    // Frame edges compare the registered vsync against the live input.
    assign frame_start = vs_q & ~CAM_vsync;
    assign frame_end   = ~vs_q & CAM_vsync;
    assign line_end    = href_q & ~CAM_href;

    assign keep      = (x_sub == '0) && (y_sub == '0);
    assign in_bounds = (out_x < XW'(IMG_W)) && (out_y < YW'(IMG_H));
    assign x_sub_nxt = (x_sub == SW'(DECIM - 1)) ? '0 : x_sub + SW'(1);
    assign y_sub_nxt = (y_sub == SW'(DECIM - 1)) ? '0 : y_sub + SW'(1);

    // Storage-format conversion of {latched high byte, current low byte}.
    always_comb begin
        pix = '0;
        case (FMT)
            1:       pix = DW'({hi_q[3:0], CAM_px_data});
            2:       pix = DW'({hi_q[7:5], hi_q[2:0], CAM_px_data[4:3]});
            default: pix = DW'({hi_q[7:4], hi_q[2:0], CAM_px_data[7], CAM_px_data[4:1]});
        endcase
    end

    // Capture control, byte assembly, decimation and write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            vs_q           <= 1'b0;
            href_q         <= 1'b0;
            phase          <= 1'b0;
            hi_q           <= '0;
            x_sub          <= '0;
            y_sub          <= '0;
            out_x          <= '0;
            out_y          <= '0;
            line_base      <= '0;
            line_kept      <= 1'b0;
            DP_RAM_regW    <= 1'b0;
            DP_RAM_addr_in <= '0;
            DP_RAM_data_in <= '0;
            frame_done     <= 1'b0;
            busy           <= 1'b0;
            overflow       <= 1'b0;
            frame_cnt      <= '0;
        end else begin
            vs_q        <= CAM_vsync;
            DP_RAM_regW <= 1'b0;
            frame_done  <= 1'b0;

            case (state)
                S_IDLE: begin
                    href_q <= 1'b0;
                    phase  <= 1'b0;
                    if (arm) begin
                        state <= S_WAIT;
                        busy  <= 1'b1;
                    end
                end

                S_WAIT: begin
                    href_q <= 1'b0;
                    phase  <= 1'b0;
                    if (frame_start) begin
                        state     <= S_CAPTURE;
                        x_sub     <= '0;
                        y_sub     <= '0;
                        out_x     <= '0;
                        out_y     <= '0;
                        line_base <= '0;
                        line_kept <= 1'b0;
                        overflow  <= 1'b0;
                    end
                end

                S_CAPTURE: begin
                    if (frame_end) begin
                        // A partial line is dropped; an already issued write still lands.
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                        href_q     <= 1'b0;
                        phase      <= 1'b0;
                    end else begin
                        href_q <= CAM_href;
                        if (CAM_href) begin
                            if (!phase) begin
                                hi_q  <= CAM_px_data;
                                phase <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                                x_sub <= x_sub_nxt;
                                if (keep) begin
                                    line_kept <= 1'b1;
                                    if (out_x < XW'(IMG_W)) begin
                                        out_x <= out_x + XW'(1);
                                    end
                                    if (in_bounds) begin
                                        DP_RAM_regW    <= 1'b1;
                                        DP_RAM_addr_in <= line_base + AW'(out_x);
                                        DP_RAM_data_in <= pix;
                                    end else begin
                                        overflow <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            // Odd trailing byte is discarded by clearing the phase.
                            phase <= 1'b0;
                            if (line_end) begin
                                x_sub     <= '0;
                                y_sub     <= y_sub_nxt;
                                out_x     <= '0;
                                line_kept <= 1'b0;
                                if (line_kept && (out_y < YW'(IMG_H))) begin
                                    out_y     <= out_y + YW'(1);
                                    line_base <= line_base + AW'(IMG_W);
                                end
                            end
                        end
                    end
                end

                S_DONE: begin
                    state <= continuous ? S_WAIT : S_IDLE;
                    busy  <= continuous;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture_param.sv
module tb_cam_capture_param;

    localparam int IW = 8;
    localparam int IH = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pxd;
    logic       href, vsync, arm, cont;

    logic        wr0, wr1, wr2;
    logic [14:0] ad0, ad1, ad2;
    logic [11:0] dt0, dt1, dt2;
    logic        fd0, fd1, fd2;
    logic        bs0, bs1, bs2;
    logic        ov0, ov1, ov2;
    logic [7:0]  fc0, fc1, fc2;

    always #5 clk = ~clk;

    cam_capture_param #(.AW(15), .DW(12), .IMG_W(IW), .IMG_H(IH), .DECIM(1), .FMT(0)) d0 (
        .clk(clk), .rst(rst), .CAM_px_data(pxd), .CAM_href(href), .CAM_vsync(vsync),
        .arm(arm), .continuous(cont), .DP_RAM_regW(wr0), .DP_RAM_addr_in(ad0),
        .DP_RAM_data_in(dt0), .frame_done(fd0), .busy(bs0), .overflow(ov0), .frame_cnt(fc0));

    cam_capture_param #(.AW(15), .DW(12), .IMG_W(IW), .IMG_H(IH), .DECIM(2), .FMT(1)) d1 (
        .clk(clk), .rst(rst), .CAM_px_data(pxd), .CAM_href(href), .CAM_vsync(vsync),
        .arm(arm), .continuous(cont), .DP_RAM_regW(wr1), .DP_RAM_addr_in(ad1),
        .DP_RAM_data_in(dt1), .frame_done(fd1), .busy(bs1), .overflow(ov1), .frame_cnt(fc1));

    cam_capture_param #(.AW(15), .DW(12), .IMG_W(IW), .IMG_H(IH), .DECIM(4), .FMT(2)) d2 (
        .clk(clk), .rst(rst), .CAM_px_data(pxd), .CAM_href(href), .CAM_vsync(vsync),
        .arm(arm), .continuous(cont), .DP_RAM_regW(wr2), .DP_RAM_addr_in(ad2),
        .DP_RAM_data_in(dt2), .frame_done(fd2), .busy(bs2), .overflow(ov2), .frame_cnt(fc2));

    int checks = 0;
    int errors = 0;

    int bytes_q[$];
    int lens_q[$];
    int got0[$], got1[$], got2[$];
    int fdc[3];
    int m_q[$];
    int m_ovf;
    int exp_fcnt = 0;
    bit watch_busy = 1'b0;
    int busy_drops = 0;

    typedef struct {
        int hi;
        int lo;
        int e0;
        int e1;
        int e2;
    } conv_vec_t;

    conv_vec_t tv[5];

    // Write/pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr0) got0.push_back(int'(ad0) * 4096 + int'(dt0));
        if (wr1) got1.push_back(int'(ad1) * 4096 + int'(dt1));
        if (wr2) got2.push_back(int'(ad2) * 4096 + int'(dt2));
        if (fd0) fdc[0]++;
        if (fd1) fdc[1]++;
        if (fd2) fdc[2]++;
        if (watch_busy && (!bs0 || !bs1 || !bs2)) busy_drops++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endfunction

    function automatic int qget(int q[$], int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Reference pixel conversion written from the bit-field rules.
    function automatic int conv(int fmt, int hi, int lo);
        int r, g, b;
        if (fmt == 1) return ((hi % 16) * 256) + lo;
        if (fmt == 2) return ((hi / 32) * 32) + ((hi % 8) * 4) + ((lo / 8) % 4);
        r = hi / 16;
        g = ((hi % 8) * 2) + (lo / 128);
        b = (lo / 2) % 16;
        return r * 256 + g * 16 + b;
    endfunction

    // Expected write list for DUT d from the current frame (lens_q/bytes_q).
    function automatic void model(int d);
        int dec, oy, idx, np, ox, a;
        bit any;
        dec = (d == 0) ? 1 : ((d == 1) ? 2 : 4);
        oy = 0;
        idx = 0;
        m_q.delete();
        m_ovf = 0;
        for (int r = 0; r < lens_q.size(); r++) begin
            np = lens_q[r] / 2;
            any = 1'b0;
            for (int p = 0; p < np; p++) begin
                if ((r % dec == 0) && (p % dec == 0)) begin
                    any = 1'b1;
                    ox = p / dec;
                    if (ox < IW && oy < IH) begin
                        a = oy * IW + ox;
                        m_q.push_back(a * 4096 + conv(d, bytes_q[idx + 2*p], bytes_q[idx + 2*p + 1]));
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (any) oy++;
            idx += lens_q[r];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got0.delete();
        got1.delete();
        got2.delete();
        for (int i = 0; i < 3; i++) fdc[i] = 0;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic drive_frame(input bit toggle_arm, input bit chk_clr);
        int idx;
        idx = 0;
        href = 1'b0;
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
        if (chk_clr) chk("ovf clear at frame start", int'(ov0), 0);
        for (int r = 0; r < lens_q.size(); r++) begin
            href = 1'b1;
            for (int b = 0; b < lens_q[r]; b++) begin
                pxd = 8'(bytes_q[idx]);
                idx++;
                if (toggle_arm) arm = 1'($urandom_range(0, 1));
                tick();
            end
            href = 1'b0;
            arm = 1'b0;
            pxd = 8'h00;
            repeat (2) tick();
        end
        vsync = 1'b1;
        repeat (3) tick();
    endtask

    task automatic rand_frame(input int max_lines, input int max_len);
        int nl, ln;
        bytes_q.delete();
        lens_q.delete();
        nl = int'($urandom_range(1, max_lines));
        for (int r = 0; r < nl; r++) begin
            ln = int'($urandom_range(1, max_len));
            lens_q.push_back(ln);
            for (int b = 0; b < ln; b++) bytes_q.push_back(int'($urandom_range(0, 255)));
        end
    endtask

    task automatic check_frame(string tag);
        int g[$];
        int ov, fc;
        for (int d = 0; d < 3; d++) begin
            model(d);
            case (d)
                0:       begin g = got0; ov = int'(ov0); fc = int'(fc0); end
                1:       begin g = got1; ov = int'(ov1); fc = int'(fc1); end
                default: begin g = got2; ov = int'(ov2); fc = int'(fc2); end
            endcase
            chk($sformatf("%s d%0d nwr", tag, d), g.size(), m_q.size());
            for (int i = 0; i < m_q.size() && i < g.size(); i++)
                chk($sformatf("%s d%0d wr%0d", tag, d, i), g[i], m_q[i]);
            chk($sformatf("%s d%0d ovf", tag, d), ov, m_ovf);
            chk($sformatf("%s d%0d fdone", tag, d), fdc[d], 1);
            chk($sformatf("%s d%0d fcnt", tag, d), fc, exp_fcnt % 256);
        end
    endtask

    initial begin
        tv[0] = '{hi: 'hF8, lo: 'h1F, e0: 'hF0F, e1: 'h81F, e2: 'h0E3};
        tv[1] = '{hi: 'hFF, lo: 'hFF, e0: 'hFFF, e1: 'hFFF, e2: 'h0FF};
        tv[2] = '{hi: 'h00, lo: 'h00, e0: 'h000, e1: 'h000, e2: 'h000};
        tv[3] = '{hi: 'h12, lo: 'h34, e0: 'h14A, e1: 'h234, e2: 'h00A};
        tv[4] = '{hi: 'hA5, lo: 'h5A, e0: 'hAAD, e1: 'h55A, e2: 'h0B7};

        rst = 1'b0; pxd = 8'h00; href = 1'b0; vsync = 1'b1; arm = 1'b0; cont = 1'b0;
        repeat (3) tick();
        chk("rst regW", int'(wr0 | wr1 | wr2), 0);
        chk("rst addr", int'(ad0 | ad1 | ad2), 0);
        chk("rst data", int'(dt0 | dt1 | dt2), 0);
        chk("rst busy", int'(bs0 | bs1 | bs2), 0);
        chk("rst fdone ovf", int'(fd0 | fd1 | fd2 | ov0 | ov1 | ov2), 0);
        chk("rst fcnt", int'(fc0 | fc1 | fc2), 0);
        rst = 1'b1;
        tick();

        // Format conversion table: one pixel per single-shot frame.
        for (int i = 0; i < 5; i++) begin
            bytes_q = '{tv[i].hi, tv[i].lo};
            lens_q = '{2};
            clear_got();
            arm_pulse();
            drive_frame(1'b0, 1'b0);
            exp_fcnt++;
            chk($sformatf("tv%0d d0 wr", i), qget(got0, 0), tv[i].e0);
            chk($sformatf("tv%0d d1 wr", i), qget(got1, 0), tv[i].e1);
            chk($sformatf("tv%0d d2 wr", i), qget(got2, 0), tv[i].e2);
            chk($sformatf("tv%0d nwr", i), got0.size() + got1.size() + got2.size(), 3);
            chk($sformatf("tv%0d fcnt", i), int'(fc0), exp_fcnt);
            chk($sformatf("tv%0d busy idle", i), int'(bs0), 0);
        end

        // Write latency, data hold and second-row base address.
        clear_got();
        arm_pulse();
        vsync = 1'b1; repeat (2) tick();
        vsync = 1'b0; repeat (2) tick();
        href = 1'b1; pxd = 8'hF8; tick();
        chk("lat first byte regW", int'(wr0), 0);
        pxd = 8'h1F; tick();
        chk("lat regW", int'(wr0), 1);
        chk("lat addr", int'(ad0), 0);
        chk("lat data", int'(dt0), 'hF0F);
        href = 1'b0; pxd = 8'h00; tick();
        chk("lat regW one cycle", int'(wr0), 0);
        chk("lat data hold", int'(dt0), 'hF0F);
        tick();
        href = 1'b1; pxd = 8'h12; tick();
        pxd = 8'h34; tick();
        chk("row1 addr", int'(ad0), IW);
        href = 1'b0; repeat (2) tick();
        vsync = 1'b1; repeat (3) tick();
        exp_fcnt++;
        chk("lat fcnt", int'(fc0), exp_fcnt);

        // Overflow on a too-wide frame, then cleared at the next frame start.
        bytes_q.delete();
        lens_q = '{20, 20, 20};
        for (int b = 0; b < 60; b++) bytes_q.push_back(int'($urandom_range(0, 255)));
        clear_got();
        arm_pulse();
        drive_frame(1'b0, 1'b0);
        exp_fcnt++;
        check_frame("wide");
        bytes_q = '{1, 2, 3, 4};
        lens_q = '{4};
        clear_got();
        arm_pulse();
        drive_frame(1'b0, 1'b1);
        exp_fcnt++;
        check_frame("after wide");

        // Odd byte counts per line.
        bytes_q.delete();
        lens_q = '{5, 3, 1, 7, 4};
        for (int b = 0; b < 20; b++) bytes_q.push_back(int'($urandom_range(0, 255)));
        clear_got();
        arm_pulse();
        drive_frame(1'b0, 1'b0);
        exp_fcnt++;
        check_frame("odd");

        // Continuous capture with arm toggling mid-frame.
        cont = 1'b1;
        arm_pulse();
        watch_busy = 1'b1;
        for (int f = 0; f < 3; f++) begin
            if (f == 2) begin
                watch_busy = 1'b0;
                cont = 1'b0;
            end
            rand_frame(8, 24);
            clear_got();
            drive_frame(1'b1, 1'b0);
            exp_fcnt++;
            check_frame($sformatf("cont%0d", f));
        end
        chk("cont busy steady", busy_drops, 0);
        chk("cont busy after stop", int'(bs0), 0);

        // Randomized single-shot frames against the reference model.
        for (int f = 0; f < 6; f++) begin
            rand_frame(14, 40);
            clear_got();
            arm_pulse();
            drive_frame(1'b0, 1'b0);
            exp_fcnt++;
            check_frame($sformatf("rnd%0d", f));
        end

        // Reset mid-line.
        clear_got();
        arm_pulse();
        vsync = 1'b1; repeat (2) tick();
        vsync = 1'b0; repeat (2) tick();
        href = 1'b1; pxd = 8'h12; tick();
        pxd = 8'h34; tick();
        chk("pre-reset regW", int'(wr0), 1);
        #2 rst = 1'b0;
        #1;
        chk("reset regW", int'(wr0 | wr1 | wr2), 0);
        chk("reset addr data", int'(ad0) + int'(dt0), 0);
        chk("reset busy fcnt", int'(bs0) + int'(fc0), 0);
        tick();
        rst = 1'b1;
        exp_fcnt = 0;
        clear_got();
        repeat (4) begin pxd = 8'($urandom_range(0, 255)); tick(); end
        href = 1'b0; repeat (2) tick();
        vsync = 1'b1; repeat (3) tick();
        vsync = 1'b0; repeat (2) tick();
        href = 1'b1; repeat (4) tick();
        href = 1'b0; repeat (2) tick();
        vsync = 1'b1; repeat (3) tick();
        chk("no writes without arm", got0.size() + got1.size() + got2.size(), 0);
        chk("no fdone without arm", fdc[0], 0);
        bytes_q = '{'hF8, 'h1F};
        lens_q = '{2};
        clear_got();
        arm_pulse();
        drive_frame(1'b0, 1'b0);
        exp_fcnt++;
        check_frame("post-reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
